alu_control_unit: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 41 ++++
 rtl/alu_ctrl_decode.sv | 63 ++++++
 rtl/alu_control_unit.sv | 38 +++
 tb/tb_alu_control_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the MIPS ALU control path: ALUOp classes, R-type funct
// codes and the ALU operation select consumed by the ALU.
package alu_ctrl_pkg;

   localparam logic [2:0] ALUOP_MEM   = 3'b000;
   localparam logic [2:0] ALUOP_BR    = 3'b001;
   localparam logic [2:0] ALUOP_RTYPE = 3'b010;
   localparam logic [2:0] ALUOP_ADDIU = 3'b011;
   localparam logic [2:0] ALUOP_ANDI  = 3'b100;
   localparam logic [2:0] ALUOP_ORI   = 3'b101;
   localparam logic [2:0] ALUOP_SLTI  = 3'b110;

   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU = 6'b100001;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU = 6'b100011;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLTX = 6'b101001;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU = 6'b101011;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
   localparam logic [5:0] FUNCT_SLL  = 6'b000000;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SRL = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic [2:0] ctrl;
      logic       uns;
      logic       ill;
   } alu_dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decoder; anything unrecognised (including X) is
// reported as illegal with an ADD select.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
(
   input  logic [2:0] aluop_i,
   input  logic [5:0] funct_i,
   output logic [2:0] ctrl_o,
   output logic       unsigned_o,
   output logic       illegal_o
);

   always_comb begin
      ctrl_o     = ALU_ADD;
      unsigned_o = 1'b0;
      illegal_o  = 1'b0;
      case (aluop_i)
         ALUOP_MEM:   ctrl_o = ALU_ADD;
         ALUOP_BR:    ctrl_o = ALU_SUB;
         ALUOP_ADDIU: begin
            ctrl_o     = ALU_ADD;
            unsigned_o = 1'b1;
         end
         ALUOP_ANDI:  ctrl_o = ALU_AND;
         ALUOP_ORI:   ctrl_o = ALU_OR;
         // sltiu is resolved downstream, so the qualifier stays low here
         ALUOP_SLTI:  ctrl_o = ALU_SLT;
         ALUOP_RTYPE: begin
            case (funct_i)
               FUNCT_ADD:  ctrl_o = ALU_ADD;
               FUNCT_ADDU: begin
                  ctrl_o     = ALU_ADD;
                  unsigned_o = 1'b1;
               end
               FUNCT_SUB:  ctrl_o = ALU_SUB;
               FUNCT_SUBU: begin
                  ctrl_o     = ALU_SUB;
                  unsigned_o = 1'b1;
               end
               FUNCT_AND:  ctrl_o = ALU_AND;
               FUNCT_OR:   ctrl_o = ALU_OR;
               FUNCT_NOR:  ctrl_o = ALU_NOR;
               FUNCT_SLT:  ctrl_o = ALU_SLT;
               FUNCT_SLTX, FUNCT_SLTU: begin
                  ctrl_o     = ALU_SLT;
                  unsigned_o = 1'b1;
               end
               FUNCT_SRL:  ctrl_o = ALU_SRL;
               FUNCT_SLL:  ctrl_o = ALU_SLL;
               default: begin
                  ctrl_o    = ALU_ADD;
                  illegal_o = 1'b1;
               end
            endcase
         end
         default: begin
            ctrl_o    = ALU_ADD;
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_control_unit.sv
// Registered ALU control: decodes ALUOp/funct and presents the result to the
// ALU stage one clock later; async reset forces an ADD select with flags low.
module alu_control_unit
   import alu_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] ALUOp,
   input  logic [5:0] funct,
   output logic [2:0] ALU_control,
   output logic       alu_unsigned,
   output logic       illegal_op
);

   alu_dec_t dec_d;
   alu_dec_t dec_q;

   alu_ctrl_decode u_decode (
      .aluop_i    (ALUOp),
      .funct_i    (funct),
      .ctrl_o     (dec_d.ctrl),
      .unsigned_o (dec_d.uns),
      .illegal_o  (dec_d.ill)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_q <= '{ctrl: ALU_ADD, uns: 1'b0, ill: 1'b0};
      end else begin
         dec_q <= dec_d;
      end
   end

   assign ALU_control  = dec_q.ctrl;
   assign alu_unsigned = dec_q.uns;
   assign illegal_op   = dec_q.ill;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit; expected {ALU_control, unsigned, illegal}
// values are hand-computed from the encoding tables.
module tb_alu_control_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] ALUOp;
   logic [5:0] funct;
   logic [2:0] ALU_control;
   logic       alu_unsigned;
   logic       illegal_op;

   int n_checks = 0;
   int n_fail   = 0;

   alu_control_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ALUOp        (ALUOp),
      .funct        (funct),
      .ALU_control  (ALU_control),
      .alu_unsigned (alu_unsigned),
      .illegal_op   (illegal_op)
   );

   always #5 clk = ~clk;

   // Drive on the falling edge, land 1 time unit after the capturing edge.
   task automatic drive(input logic [2:0] op, input logic [5:0] f);
      @(negedge clk);
      ALUOp = op;
      funct = f;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [4:0] got;
      rst_n = 1'b0;
      ALUOp = 3'b010;
      funct = 6'b100100;
      repeat (2) @(posedge clk);
      #1;
      got = {ALU_control, alu_unsigned, illegal_op};
      n_checks++;
      if (got !== 5'b010_0_0) begin
         n_fail++;
         $display("FAIL reset_hold: got %b expected %b", got, 5'b010_0_0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      got = {ALU_control, alu_unsigned, illegal_op};
      n_checks++;
      if (got !== 5'b010_0_0) begin
         n_fail++;
         $display("FAIL reset_release_no_edge: got %b expected %b", got, 5'b010_0_0);
      end
      @(posedge clk);
      #1;
      got = {ALU_control, alu_unsigned, illegal_op};
      n_checks++;
      if (got !== 5'b000_0_0) begin
         n_fail++;
         $display("FAIL reset_first_decode: got %b expected %b", got, 5'b000_0_0);
      end
   endtask

   task automatic test_non_rtype;
      logic [2:0] ops [6]  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b011};
      logic [4:0] exps [6] = '{5'b010_0_0, 5'b110_0_0, 5'b000_0_0,
                               5'b001_0_0, 5'b111_0_0, 5'b010_1_0};
      logic [5:0] fs [2]   = '{6'b000000, 6'b111111};
      logic [4:0] got;
      for (int j = 0; j < 2; j++) begin
         for (int i = 0; i < 6; i++) begin
            drive(ops[i], fs[j]);
            got = {ALU_control, alu_unsigned, illegal_op};
            n_checks++;
            if (got !== exps[i]) begin
               n_fail++;
               $display("FAIL non_rtype op=%b funct=%b: got %b expected %b",
                        ops[i], fs[j], got, exps[i]);
            end
         end
      end
   endtask

   task automatic test_rtype;
      logic [5:0] fs [13]   = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                6'b100100, 6'b100101, 6'b100111, 6'b101010,
                                6'b101001, 6'b101011, 6'b000010, 6'b000000,
                                6'b100000};
      logic [4:0] exps [13] = '{5'b010_0_0, 5'b010_1_0, 5'b110_0_0, 5'b110_1_0,
                                5'b000_0_0, 5'b001_0_0, 5'b100_0_0, 5'b111_0_0,
                                5'b111_1_0, 5'b111_1_0, 5'b011_0_0, 5'b101_0_0,
                                5'b010_0_0};
      logic [4:0] got;
      for (int i = 0; i < 13; i++) begin
         drive(3'b010, fs[i]);
         got = {ALU_control, alu_unsigned, illegal_op};
         n_checks++;
         if (got !== exps[i]) begin
            n_fail++;
            $display("FAIL rtype funct=%b: got %b expected %b", fs[i], got, exps[i]);
         end
      end
   endtask

   task automatic test_illegal;
      logic [2:0] ops [6]  = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b111, 3'b001};
      logic [5:0] fs [6]   = '{6'b001000, 6'b100110, 6'b000011, 6'b100000,
                               6'b000000, 6'b001000};
      logic [4:0] exps [6] = '{5'b010_0_1, 5'b010_0_1, 5'b010_0_1, 5'b010_0_1,
                               5'b010_0_1, 5'b110_0_0};
      logic [4:0] got;
      for (int i = 0; i < 6; i++) begin
         drive(ops[i], fs[i]);
         got = {ALU_control, alu_unsigned, illegal_op};
         n_checks++;
         if (got !== exps[i]) begin
            n_fail++;
            $display("FAIL illegal op=%b funct=%b: got %b expected %b",
                     ops[i], fs[i], got, exps[i]);
         end
      end
   endtask

   task automatic test_latency;
      logic [4:0] got;
      drive(3'b100, 6'b000000);
      @(negedge clk);
      ALUOp = 3'b011;
      #1;
      got = {ALU_control, alu_unsigned, illegal_op};
      n_checks++;
      if (got !== 5'b000_0_0) begin
         n_fail++;
         $display("FAIL latency_before_edge: got %b expected %b", got, 5'b000_0_0);
      end
      @(posedge clk);
      #1;
      ALUOp = 3'b101;
      #2;
      got = {ALU_control, alu_unsigned, illegal_op};
      n_checks++;
      if (got !== 5'b010_1_0) begin
         n_fail++;
         $display("FAIL latency_mid_cycle_change: got %b expected %b", got, 5'b010_1_0);
      end
      @(posedge clk);
      #1;
      got = {ALU_control, alu_unsigned, illegal_op};
      n_checks++;
      if (got !== 5'b001_0_0) begin
         n_fail++;
         $display("FAIL latency_capture: got %b expected %b", got, 5'b001_0_0);
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0] ops [5]  = '{3'b010, 3'b010, 3'b111, 3'b011, 3'b010};
      logic [5:0] fs [5]   = '{6'b100111, 6'b100011, 6'b100111, 6'b111111, 6'b000010};
      logic [4:0] exps [5] = '{5'b100_0_0, 5'b110_1_0, 5'b010_0_1, 5'b010_1_0, 5'b011_0_0};
      logic [4:0] got;
      for (int i = 0; i < 5; i++) begin
         drive(ops[i], fs[i]);
         got = {ALU_control, alu_unsigned, illegal_op};
         n_checks++;
         if (got !== exps[i]) begin
            n_fail++;
            $display("FAIL back_to_back step %0d: got %b expected %b", i, got, exps[i]);
         end
      end
   endtask

   task automatic test_midrun_reset;
      logic [4:0] got;
      drive(3'b010, 6'b101010);
      got = {ALU_control, alu_unsigned, illegal_op};
      n_checks++;
      if (got !== 5'b111_0_0) begin
         n_fail++;
         $display("FAIL midrun_pre: got %b expected %b", got, 5'b111_0_0);
      end
      #1;
      rst_n = 1'b0;
      #1;
      got = {ALU_control, alu_unsigned, illegal_op};
      n_checks++;
      if (got !== 5'b010_0_0) begin
         n_fail++;
         $display("FAIL midrun_async_reset: got %b expected %b", got, 5'b010_0_0);
      end
      #1;
      rst_n = 1'b1;
      #1;
      got = {ALU_control, alu_unsigned, illegal_op};
      n_checks++;
      if (got !== 5'b010_0_0) begin
         n_fail++;
         $display("FAIL midrun_release_hold: got %b expected %b", got, 5'b010_0_0);
      end
      @(posedge clk);
      #1;
      got = {ALU_control, alu_unsigned, illegal_op};
      n_checks++;
      if (got !== 5'b111_0_0) begin
         n_fail++;
         $display("FAIL midrun_resume: got %b expected %b", got, 5'b111_0_0);
      end
   endtask

   initial begin
      test_reset();
      test_non_rtype();
      test_rtype();
      test_illegal();
      test_latency();
      test_back_to_back();
      test_midrun_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
